// File: rtl/serial_byte_loader.sv
// serial_byte_loader
//   Assembles an 8-bit byte from a qualified serial bit stream and commits it
//   to the downstream byte_memory stage (transparent D-latch array) through a
//   registered data bus and a one-cycle store strobe. data only changes on the
//   edge that raises store, so it is stable while store is high and afterwards.
//
//   Optional feature macro: SERIAL_BYTE_LOADER_PARITY_EN
//     defined   -> a ninth (even parity) bit follows the data bits; a bad
//                  parity bit drops the frame and sets the sticky err flag.
//     undefined -> the 8th data bit commits directly; err is tied 0.
//
// Parameters
//   LSB_FIRST   1: first received bit lands in data[0]; 0: in data[7].
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   frame_start in   one-cycle request to begin a new byte
//   bit_in      in   serial data bit
//   bit_valid   in   bit_in is sampled on edges where this is high
//   abort       in   discard the frame in progress
//   data        out  [7:0] registered committed byte (to byte_memory.data)
//   store       out  registered one-cycle commit strobe (to byte_memory.store)
//   busy        out  high in any state other than IDLE
//   bit_cnt     out  [3:0] data bits accepted in the current frame (0..8)
//   byte_count  out  [7:0] committed bytes, modulo 256
//   err         out  sticky parity error flag
module serial_byte_loader #(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       abort,
  output logic [7:0] data,
  output logic       store,
  output logic       busy,
  output logic [3:0] bit_cnt,
  output logic [7:0] byte_count,
  output logic       err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0] r_state;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_store;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_byte_count;
  logic [7:0] w_shift_next;
  logic       w_last_bit;

  // Shift direction is fixed by the parameter, so the bit-to-position
  // mapping never changes within a frame.
  always_comb begin
    if (LSB_FIRST != 0) w_shift_next = {bit_in, r_shift[7:1]};
    else                w_shift_next = {r_shift[6:0], bit_in};
  end

  assign w_last_bit = (r_bit_cnt == 4'd7);

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  logic r_err;
  logic w_parity_ok;

  // Even parity: XOR over the eight data bits and the parity bit is zero.
  assign w_parity_ok = ~(^r_shift ^ bit_in);
  assign err         = r_err;
`else
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_data       <= '0;
      r_store      <= 1'b0;
      r_bit_cnt    <= '0;
      r_byte_count <= '0;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
      r_err        <= 1'b0;
`endif
    end else begin
      // store is only ever raised for the single edge entering COMMIT.
      r_store <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state   <= S_SHIFT;
            r_bit_cnt <= '0;
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
            r_err     <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
          end else if (bit_valid) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (w_last_bit) begin
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
              r_state      <= S_PARITY;
`else
              r_state      <= S_COMMIT;
              r_data       <= w_shift_next;
              r_store      <= 1'b1;
              r_byte_count <= r_byte_count + 8'd1;
`endif
            end
          end
        end
`ifdef SERIAL_BYTE_LOADER_PARITY_EN
        S_PARITY: begin
          if (abort) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
          end else if (bit_valid) begin
            if (w_parity_ok) begin
              r_state      <= S_COMMIT;
              r_data       <= r_shift;
              r_store      <= 1'b1;
              r_byte_count <= r_byte_count + 8'd1;
            end else begin
              r_state <= S_IDLE;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        S_COMMIT: begin
          // bit_valid and abort are ignored here; only frame_start matters.
          if (frame_start) begin
            r_state   <= S_SHIFT;
            r_bit_cnt <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data       = r_data;
  assign store      = r_store;
  assign busy       = (r_state != S_IDLE);
  assign bit_cnt    = r_bit_cnt;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_serial_byte_loader.sv
module tb_serial_byte_loader;

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       abort = 1'b0;

  logic [7:0] data_l, data_m;
  logic       store_l, store_m;
  logic       busy_l, busy_m;
  logic [3:0] cnt_l, cnt_m;
  logic [7:0] bc_l, bc_m;
  logic       err_l, err_m;

  serial_byte_loader #(.LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .abort(abort), .data(data_l), .store(store_l),
    .busy(busy_l), .bit_cnt(cnt_l), .byte_count(bc_l), .err(err_l)
  );

  serial_byte_loader #(.LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .abort(abort), .data(data_m), .store(store_m),
    .busy(busy_m), .bit_cnt(cnt_m), .byte_count(bc_m), .err(err_m)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: a frame is a list of bit positions being filled.
  bit         m_active, m_ppend, m_store, m_err;
  int         m_nbits, m_bc;
  logic [7:0] m_acc_l, m_acc_m, m_data_l, m_data_m;

  task automatic model_reset();
    m_active = 0; m_ppend = 0; m_store = 0; m_err = 0;
    m_nbits = 0; m_bc = 0;
    m_acc_l = '0; m_acc_m = '0; m_data_l = '0; m_data_m = '0;
  endtask

  task automatic model_commit();
    m_data_l = m_acc_l;
    m_data_m = m_acc_m;
    m_store  = 1;
    m_bc     = (m_bc + 1) % 256;
  endtask

  task automatic model_step(input bit fs, input bit bv, input bit bi, input bit ab);
    if (m_store) begin
      m_store = 0;
      if (fs) begin m_active = 1; m_nbits = 0; end
      else m_active = 0;
    end else if (!m_active) begin
      if (fs) begin m_active = 1; m_nbits = 0; m_err = 0; end
    end else if (ab) begin
      m_active = 0; m_nbits = 0; m_ppend = 0;
    end else if (bv && m_ppend) begin
      m_ppend = 0;
      if ((($countones(m_acc_l) + int'(bi)) % 2) == 0) model_commit();
      else begin m_active = 0; m_err = 1; end
    end else if (bv) begin
      m_acc_l[m_nbits]     = bi;
      m_acc_m[7 - m_nbits] = bi;
      m_nbits++;
      if (m_nbits == 8) begin
        if (PAR) m_ppend = 1;
        else model_commit();
      end
    end
  endtask

  task automatic model_compare();
    chk("store",      {31'd0, store_l}, {31'd0, m_store});
    chk("store_msb",  {31'd0, store_m}, {31'd0, m_store});
    chk("busy",       {31'd0, busy_l},  {31'd0, m_active});
    chk("bit_cnt",    {28'd0, cnt_l},   m_nbits);
    chk("byte_count", {24'd0, bc_l},    m_bc);
    chk("data_lsb",   {24'd0, data_l},  {24'd0, m_data_l});
    chk("data_msb",   {24'd0, data_m},  {24'd0, m_data_m});
    chk("err",        {31'd0, err_l},   {31'd0, m_err});
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later, check model.
  task automatic cycle(input bit fs, input bit bv, input bit bi, input bit ab);
    frame_start = fs; bit_valid = bv; bit_in = bi; abort = ab;
    @(posedge clk);
    #1;
    model_step(fs, bv, bi, ab);
    model_compare();
  endtask

  typedef struct {
    bit fs, bv, bi, ab;
    bit exp_store, exp_busy;
    logic [3:0] exp_cnt;
    logic [7:0] exp_data, exp_bc;
  } vec_t;

  function automatic vec_t mk(bit fs, bit bv, bit bi, bit ab, bit st, bit bz,
                              logic [3:0] c, logic [7:0] d, logic [7:0] b);
    vec_t v;
    v.fs = fs; v.bv = bv; v.bi = bi; v.ab = ab;
    v.exp_store = st; v.exp_busy = bz; v.exp_cnt = c; v.exp_data = d; v.exp_bc = b;
    return v;
  endfunction

  vec_t tbl[33];

  initial begin
    logic [7:0] rb;
    bit         pb;

    // ---- power-on reset ----
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_store", {31'd0, store_l}, 32'd0);
    chk("rst_busy",  {31'd0, busy_l},  32'd0);
    chk("rst_data",  {24'd0, data_l},  32'd0);
    chk("rst_bc",    {24'd0, bc_l},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table: A5 with gaps, back-to-back 3C, abort on 8th bit ----
    tbl[0]  = mk(1,0,0,0, 0,1,0,8'h00,0);
    tbl[1]  = mk(0,1,1,0, 0,1,1,8'h00,0);
    tbl[2]  = mk(0,0,0,0, 0,1,1,8'h00,0);
    tbl[3]  = mk(0,1,0,0, 0,1,2,8'h00,0);
    tbl[4]  = mk(0,1,1,0, 0,1,3,8'h00,0);
    tbl[5]  = mk(0,0,0,0, 0,1,3,8'h00,0);
    tbl[6]  = mk(0,1,0,0, 0,1,4,8'h00,0);
    tbl[7]  = mk(0,1,0,0, 0,1,5,8'h00,0);
    tbl[8]  = mk(0,1,1,0, 0,1,6,8'h00,0);
    tbl[9]  = mk(0,0,1,0, 0,1,6,8'h00,0);
    tbl[10] = mk(0,1,0,0, 0,1,7,8'h00,0);
    tbl[11] = mk(0,1,1,0, 1,1,8,8'hA5,1);
    tbl[12] = mk(1,1,1,1, 0,1,0,8'hA5,1);
    tbl[13] = mk(0,1,0,0, 0,1,1,8'hA5,1);
    tbl[14] = mk(0,1,0,0, 0,1,2,8'hA5,1);
    tbl[15] = mk(0,1,1,0, 0,1,3,8'hA5,1);
    tbl[16] = mk(0,1,1,0, 0,1,4,8'hA5,1);
    tbl[17] = mk(0,1,1,0, 0,1,5,8'hA5,1);
    tbl[18] = mk(0,1,1,0, 0,1,6,8'hA5,1);
    tbl[19] = mk(0,1,0,0, 0,1,7,8'hA5,1);
    tbl[20] = mk(0,1,0,0, 1,1,8,8'h3C,2);
    tbl[21] = mk(0,0,0,1, 0,0,8,8'h3C,2);
    tbl[22] = mk(1,0,0,0, 0,1,0,8'h3C,2);
    tbl[23] = mk(0,1,1,0, 0,1,1,8'h3C,2);
    tbl[24] = mk(0,1,1,0, 0,1,2,8'h3C,2);
    tbl[25] = mk(1,1,1,0, 0,1,3,8'h3C,2);
    tbl[26] = mk(0,1,1,0, 0,1,4,8'h3C,2);
    tbl[27] = mk(0,1,1,0, 0,1,5,8'h3C,2);
    tbl[28] = mk(0,1,1,0, 0,1,6,8'h3C,2);
    tbl[29] = mk(0,1,1,0, 0,1,7,8'h3C,2);
    tbl[30] = mk(0,1,1,1, 0,0,0,8'h3C,2);
    tbl[31] = mk(0,1,1,0, 0,0,0,8'h3C,2);
    tbl[32] = mk(0,0,0,1, 0,0,0,8'h3C,2);

    if (!PAR) begin
      for (int i = 0; i < 33; i++) begin
        cycle(tbl[i].fs, tbl[i].bv, tbl[i].bi, tbl[i].ab);
        chk($sformatf("tbl%0d_store", i), {31'd0, store_l}, {31'd0, tbl[i].exp_store});
        chk($sformatf("tbl%0d_busy", i),  {31'd0, busy_l},  {31'd0, tbl[i].exp_busy});
        chk($sformatf("tbl%0d_cnt", i),   {28'd0, cnt_l},   {28'd0, tbl[i].exp_cnt});
        chk($sformatf("tbl%0d_data", i),  {24'd0, data_l},  {24'd0, tbl[i].exp_data});
        chk($sformatf("tbl%0d_bc", i),    {24'd0, bc_l},    {24'd0, tbl[i].exp_bc});
      end
    end

    // ---- reset asserted while store is high ----
    cycle(1, 0, 0, 0);
    for (int b = 0; b < 8; b++) cycle(0, 1, $urandom_range(0, 1), 0);
    if (PAR) cycle(0, 1, ^m_acc_l, 0);
    chk("pre_rst_store", {31'd0, store_l}, 32'd1);
    frame_start = 0; bit_valid = 0; bit_in = 0; abort = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_store", {31'd0, store_l}, 32'd0);
    chk("midrst_busy",  {31'd0, busy_l},  32'd0);
    chk("midrst_cnt",   {28'd0, cnt_l},   32'd0);
    chk("midrst_data",  {24'd0, data_l},  32'd0);
    chk("midrst_datam", {24'd0, data_m},  32'd0);
    chk("midrst_bc",    {24'd0, bc_l},    32'd0);
    chk("midrst_err",   {31'd0, err_l},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0);
    chk("idle_bv_cnt", {28'd0, cnt_l}, 32'd0);

    // ---- 256 back-to-back frames wrap byte_count ----
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 256; k++) begin
      rb = 8'($urandom);
      for (int b = 0; b < 8; b++) cycle(0, 1, rb[b], 0);
      if (PAR) cycle(0, 1, ^rb, 0);
      chk("wrap_data", {24'd0, data_l}, {24'd0, rb});
      cycle(k < 255, 0, 0, 0);
    end
    chk("wrap_bc", {24'd0, bc_l}, 32'd0);

`ifdef SERIAL_BYTE_LOADER_PARITY_EN
    // ---- parity: 0x01 with good then bad parity bit ----
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    for (int b = 1; b < 8; b++) cycle(0, 1, 0, 0);
    chk("par_cnt", {28'd0, cnt_l}, 32'd8);
    cycle(0, 1, 1, 0);
    chk("par_good_store", {31'd0, store_l}, 32'd1);
    chk("par_good_err",   {31'd0, err_l},   32'd0);
    chk("par_good_data",  {24'd0, data_l},  32'h01);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    for (int b = 1; b < 8; b++) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("par_bad_store", {31'd0, store_l}, 32'd0);
    chk("par_bad_err",   {31'd0, err_l},   32'd1);
    chk("par_bad_busy",  {31'd0, busy_l},  32'd0);
    cycle(0, 0, 0, 0);
    chk("par_err_hold",  {31'd0, err_l},   32'd1);
    cycle(1, 0, 0, 0);
    chk("par_err_clr",   {31'd0, err_l},   32'd0);
`endif

    // ---- randomized traffic against the reference model ----
    for (int i = 0; i < 3000; i++) begin
      pb = ($urandom_range(0, 5) == 0);
      cycle(pb, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 24) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
